grid_frame_sequencer: RTL and testbench

Sequences all writes into the double-buffered 30x40 LED grid RAM once per game step. On each `tick` it clears the back buffer, fetches snake segment coordinates from the snake logic over a req/ack handshake, plots them and the food pixel, then swaps buffers. It sits between the 10 Hz game-step logic and the grid RAM / display scan-out, and is the only writer of the grid RAM.

---
 rtl/grid_pkg.sv | 28 ++
 rtl/grid_addr_calc.sv | 20 ++
 rtl/grid_frame_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_grid_frame_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grid_pkg
// Purpose  : Shared grid geometry, widths and frame-sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package grid_pkg;

    localparam int GRID_ROWS  = 30;
    localparam int GRID_COLS  = 40;
    localparam int RAM_LENGTH = GRID_ROWS * GRID_COLS;
    localparam int COORD_W    = 6;
    localparam int ADDR_W     = 11;
    localparam int MAX_SEGS   = 15;
    localparam int SEG_CNT_W  = 5;
    localparam int SEG_IDX_W  = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_FETCH = 3'd2;
    localparam state_t ST_PLOT  = 3'd3;
    localparam state_t ST_FOOD  = 3'd4;
    localparam state_t ST_SWAP  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/grid_addr_calc.sv
`default_nettype none
// ============================================================================
// Module   : grid_addr_calc
// Purpose  : Row-major cell address (y*GRID_COLS + x) and in-range flag.
// Revision : 1.0 - initial release
// ============================================================================
module grid_addr_calc
    import grid_pkg::*;
(
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_in_range
);

    assign o_in_range = (i_x < COORD_W'(GRID_COLS)) && (i_y < COORD_W'(GRID_ROWS));
    assign o_addr     = ADDR_W'(i_y) * ADDR_W'(GRID_COLS) + ADDR_W'(i_x);

endmodule
`default_nettype wire

// File: rtl/grid_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : grid_frame_sequencer
// Purpose  : Per-tick clear / plot segments / plot food / swap of the
//            double-buffered LED grid RAM.
// Revision : 1.0 - initial release
// ============================================================================
module grid_frame_sequencer
    import grid_pkg::*;
(
    input  logic                 clk_74a,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [SEG_CNT_W-1:0] seg_count,
    output logic                 seg_req,
    output logic [SEG_IDX_W-1:0] seg_idx,
    input  logic                 seg_ack,
    input  logic [COORD_W-1:0]   seg_x,
    input  logic [COORD_W-1:0]   seg_y,
    input  logic                 food_valid,
    input  logic [COORD_W-1:0]   food_x,
    input  logic [COORD_W-1:0]   food_y,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 wr_data,
    output logic                 buf_sel,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic                 coord_err
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(RAM_LENGTH - 1);

    state_t                r_state,      w_state_nxt;
    logic                  r_wr_en,      w_wr_en_nxt;
    logic                  r_wr_data,    w_wr_data_nxt;
    logic [ADDR_W-1:0]     r_wr_addr,    w_wr_addr_nxt;
    logic                  r_seg_req,    w_seg_req_nxt;
    logic [SEG_IDX_W-1:0]  r_seg_idx,    w_seg_idx_nxt;
    logic                  r_buf_sel,    w_buf_sel_nxt;
    logic                  r_busy,       w_busy_nxt;
    logic                  r_frame_done, w_frame_done_nxt;
    logic                  r_overrun,    w_overrun_nxt;
    logic                  r_coord_err,  w_coord_err_nxt;
    logic [SEG_IDX_W-1:0]  r_count,      w_count_nxt;
    logic                  r_food_valid, w_food_valid_nxt;
    logic [COORD_W-1:0]    r_food_x,     w_food_x_nxt;
    logic [COORD_W-1:0]    r_food_y,     w_food_y_nxt;
    logic                  w_enter_food;

    logic [COORD_W-1:0]    w_calc_x;
    logic [COORD_W-1:0]    w_calc_y;
    logic [ADDR_W-1:0]     w_calc_addr;
    logic                  w_calc_in_range;

    // The write address is formed on the edge that enters PLOT/FOOD, so the
    // calculator sees the live segment bus in FETCH and the latched food otherwise.
    assign w_calc_x = (r_state == ST_FETCH) ? seg_x : r_food_x;
    assign w_calc_y = (r_state == ST_FETCH) ? seg_y : r_food_y;

    grid_addr_calc u_addr_calc (
        .i_x        (w_calc_x),
        .i_y        (w_calc_y),
        .o_addr     (w_calc_addr),
        .o_in_range (w_calc_in_range)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_en_nxt      = 1'b0;
        w_wr_data_nxt    = 1'b0;
        w_wr_addr_nxt    = r_wr_addr;
        w_seg_req_nxt    = 1'b0;
        w_seg_idx_nxt    = r_seg_idx;
        w_buf_sel_nxt    = r_buf_sel;
        w_frame_done_nxt = 1'b0;
        w_overrun_nxt    = r_overrun;
        w_coord_err_nxt  = r_coord_err;
        w_count_nxt      = r_count;
        w_food_valid_nxt = r_food_valid;
        w_food_x_nxt     = r_food_x;
        w_food_y_nxt     = r_food_y;
        w_enter_food     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (tick) begin
                    w_state_nxt      = ST_CLEAR;
                    w_count_nxt      = (seg_count > SEG_CNT_W'(MAX_SEGS)) ?
                                       SEG_IDX_W'(MAX_SEGS) : seg_count[SEG_IDX_W-1:0];
                    w_food_valid_nxt = food_valid;
                    w_food_x_nxt     = food_x;
                    w_food_y_nxt     = food_y;
                    w_seg_idx_nxt    = '0;
                    w_wr_en_nxt      = 1'b1;
                    w_wr_addr_nxt    = '0;
                end
            end
            ST_CLEAR: begin
                if (r_wr_addr == c_last_addr) begin
                    if (r_count != '0) begin
                        w_state_nxt   = ST_FETCH;
                        w_seg_req_nxt = 1'b1;
                        w_seg_idx_nxt = '0;
                    end else begin
                        w_enter_food = 1'b1;
                    end
                end else begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_wr_addr + 1'b1;
                end
            end
            ST_FETCH: begin
                if (seg_ack) begin
                    w_state_nxt = ST_PLOT;
                    if (w_calc_in_range) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_data_nxt = 1'b1;
                        w_wr_addr_nxt = w_calc_addr;
                    end else begin
                        w_coord_err_nxt = 1'b1;
                    end
                end else begin
                    w_seg_req_nxt = 1'b1;
                end
            end
            ST_PLOT: begin
                if (({1'b0, r_seg_idx} + 5'd1) < {1'b0, r_count}) begin
                    w_state_nxt   = ST_FETCH;
                    w_seg_req_nxt = 1'b1;
                    w_seg_idx_nxt = r_seg_idx + 1'b1;
                end else begin
                    w_enter_food = 1'b1;
                end
            end
            ST_FOOD: begin
                w_state_nxt = ST_SWAP;
            end
            ST_SWAP: begin
                w_state_nxt      = ST_IDLE;
                w_buf_sel_nxt    = ~r_buf_sel;
                w_frame_done_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_enter_food) begin
            w_state_nxt = ST_FOOD;
            if (r_food_valid) begin
                if (w_calc_in_range) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_data_nxt = 1'b1;
                    w_wr_addr_nxt = w_calc_addr;
                end else begin
                    w_coord_err_nxt = 1'b1;
                end
            end
        end

        if (tick && (r_state != ST_IDLE)) begin
            w_overrun_nxt = 1'b1;
        end
    end

    assign w_busy_nxt = (w_state_nxt != ST_IDLE);

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_en      <= 1'b0;
            r_wr_data    <= 1'b0;
            r_wr_addr    <= '0;
            r_seg_req    <= 1'b0;
            r_seg_idx    <= '0;
            r_buf_sel    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_coord_err  <= 1'b0;
            r_count      <= '0;
            r_food_valid <= 1'b0;
            r_food_x     <= '0;
            r_food_y     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_seg_req    <= w_seg_req_nxt;
            r_seg_idx    <= w_seg_idx_nxt;
            r_buf_sel    <= w_buf_sel_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_overrun    <= w_overrun_nxt;
            r_coord_err  <= w_coord_err_nxt;
            r_count      <= w_count_nxt;
            r_food_valid <= w_food_valid_nxt;
            r_food_x     <= w_food_x_nxt;
            r_food_y     <= w_food_y_nxt;
        end
    end

    assign seg_req    = r_seg_req;
    assign seg_idx    = r_seg_idx;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign buf_sel    = r_buf_sel;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign coord_err  = r_coord_err;

endmodule
`default_nettype wire

// File: tb/tb_grid_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_frame_sequencer
// Purpose  : Directed and randomized frames checked against a write-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_frame_sequencer;

    logic        clk_74a = 1'b0;
    logic        reset   = 1'b1;
    logic        tick    = 1'b0;
    logic [4:0]  seg_count = '0;
    logic        seg_req;
    logic [3:0]  seg_idx;
    logic        seg_ack = 1'b0;
    logic [5:0]  seg_x = '0;
    logic [5:0]  seg_y = '0;
    logic        food_valid = 1'b0;
    logic [5:0]  food_x = '0;
    logic [5:0]  food_y = '0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic        wr_data;
    logic        buf_sel;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic        coord_err;

    always #5 clk_74a = ~clk_74a;

    grid_frame_sequencer dut (
        .clk_74a    (clk_74a),
        .reset      (reset),
        .tick       (tick),
        .seg_count  (seg_count),
        .seg_req    (seg_req),
        .seg_idx    (seg_idx),
        .seg_ack    (seg_ack),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .food_valid (food_valid),
        .food_x     (food_x),
        .food_y     (food_y),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .buf_sel    (buf_sel),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .coord_err  (coord_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // frame description consumed by run_frame
    int f_cnt;
    bit f_food_v;
    int f_fx, f_fy;
    int sx[32];
    int sy[32];
    int dly[32];

    // sticky/visible-state model
    bit exp_buf = 1'b0;
    bit exp_cerr = 1'b0;
    bit exp_ovr = 1'b0;

    int exp_w[$];
    int got_w[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_74a);
        #1;
    endtask

    function automatic bit in_rng(input int x, input int y);
        return (x < 40) && (y < 30);
    endfunction

    task automatic run_frame(input string name, input bit b2b, input bit ovr_tick);
        int n, exp_fd, c, fd, bad, idx_bad, cur, wc;
        bit err;
        n = (f_cnt > 15) ? 15 : f_cnt;
        exp_w.delete();
        got_w.delete();
        for (int a = 0; a < 1200; a++) exp_w.push_back(a * 2);
        err = 1'b0;
        exp_fd = 1203;
        for (int i = 0; i < n; i++) begin
            exp_fd += 2 + dly[i];
            if (in_rng(sx[i], sy[i])) exp_w.push_back((sy[i] * 40 + sx[i]) * 2 + 1);
            else err = 1'b1;
        end
        if (f_food_v) begin
            if (in_rng(f_fx, f_fy)) exp_w.push_back((f_fy * 40 + f_fx) * 2 + 1);
            else err = 1'b1;
        end
        if (!b2b) begin
            step();
            step();
        end
        seg_count  = 5'(f_cnt);
        food_valid = f_food_v;
        food_x     = 6'(f_fx);
        food_y     = 6'(f_fy);
        tick = 1'b1;
        step();
        tick = 1'b0;
        c = 1; fd = -1; idx_bad = 0; cur = 0; wc = 0;
        chk({name, "_busy_rise"}, busy, 1);
        while (c < 4000) begin
            if (wr_en) got_w.push_back(int'(wr_addr) * 2 + int'(wr_data));
            if (frame_done) begin
                fd = c;
                break;
            end
            if (seg_req) begin
                if (cur >= 32 || seg_idx !== 4'(cur)) idx_bad++;
                if (cur < 32 && wc == dly[cur]) begin
                    seg_ack = 1'b1;
                    seg_x = 6'(sx[cur]);
                    seg_y = 6'(sy[cur]);
                end else begin
                    seg_ack = 1'b0;
                    seg_x = 6'($urandom);
                    seg_y = 6'($urandom);
                    wc++;
                end
            end else begin
                if (seg_ack) begin
                    cur++;
                    wc = 0;
                end
                seg_ack = 1'b0;
            end
            if (ovr_tick) tick = (c == 100);
            if (c == 2) begin
                seg_count  = 5'($urandom);
                food_valid = 1'($urandom);
                food_x     = 6'($urandom);
                food_y     = 6'($urandom);
            end
            step();
            c++;
        end
        tick = 1'b0;
        if (ovr_tick) exp_ovr = 1'b1;
        exp_cerr = exp_cerr | err;
        exp_buf  = ~exp_buf;
        bad = 0;
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            if (got_w[i] != exp_w[i]) bad++;
        chk({name, "_frame_done_cycle"}, fd, exp_fd);
        chk({name, "_write_count"}, got_w.size(), exp_w.size());
        chk({name, "_write_mismatches"}, bad, 0);
        chk({name, "_seg_idx_unstable"}, idx_bad, 0);
        chk({name, "_fetches"}, cur, n);
        chk({name, "_busy_fall"}, busy, 0);
        chk({name, "_buf_sel"}, buf_sel, exp_buf);
        chk({name, "_coord_err"}, coord_err, exp_cerr);
        chk({name, "_overrun"}, overrun, exp_ovr);
    endtask

    task automatic clear_segs();
        for (int i = 0; i < 32; i++) begin
            sx[i] = 0; sy[i] = 0; dly[i] = 0;
        end
    endtask

    initial begin
        int got_req;
        // reset state
        step();
        step();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_buf_sel", buf_sel, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_seg_req", seg_req, 0);
        chk("rst_sticky", {overrun, coord_err}, 0);
        reset = 1'b0;

        // five in-range segments, no food, zero-wait ack
        clear_segs();
        f_cnt = 5; f_food_v = 0; f_fx = 0; f_fy = 0;
        for (int i = 0; i < 5; i++) begin sx[i] = 20 + i; sy[i] = 15; end
        run_frame("zero_wait", 0, 0);

        // same segments, ack three cycles late
        for (int i = 0; i < 5; i++) dly[i] = 3;
        run_frame("late_ack", 0, 0);

        // out-of-range segment plus corner food
        clear_segs();
        f_cnt = 1; sx[0] = 40; sy[0] = 0;
        f_food_v = 1; f_fx = 0; f_fy = 29;
        run_frame("bad_seg", 0, 0);

        // no segments, food at last cell
        clear_segs();
        f_cnt = 0; f_food_v = 1; f_fx = 39; f_fy = 29;
        run_frame("no_segs", 0, 0);

        // stray tick in CLEAR, then a tick coincident with frame_done
        f_cnt = 2; sx[0] = 3; sy[0] = 4; sx[1] = 3; sy[1] = 4; f_food_v = 0;
        run_frame("overrun", 0, 1);
        f_cnt = 18;
        for (int i = 0; i < 18; i++) begin sx[i] = i; sy[i] = 29 - i; dly[i] = i % 3; end
        f_food_v = 1; f_fx = 63; f_fy = 2;
        run_frame("b2b_clamp", 1, 0);

        // randomized frames
        for (int r = 0; r < 4; r++) begin
            clear_segs();
            f_cnt = int'($urandom_range(0, 20));
            for (int i = 0; i < 20; i++) begin
                sx[i]  = int'($urandom_range(0, 44));
                sy[i]  = int'($urandom_range(0, 33));
                dly[i] = int'($urandom_range(0, 3));
            end
            f_food_v = 1'($urandom);
            f_fx = int'($urandom_range(0, 42));
            f_fy = int'($urandom_range(0, 31));
            run_frame("random", (r == 2), 0);
        end

        // reset mid-CLEAR: write strobe must drop without a clock edge
        seg_count = 5'd3; food_valid = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (50) step();
        #2 reset = 1'b1;
        #1;
        chk("rst_clear_wr_en", wr_en, 0);
        chk("rst_clear_busy", busy, 0);
        chk("rst_clear_buf_sel", buf_sel, 0);
        step();
        reset = 1'b0;
        exp_buf = 1'b0; exp_cerr = 1'b0; exp_ovr = 1'b0;

        // reset mid-FETCH with ack withheld
        seg_count = 5'd3;
        tick = 1'b1;
        step();
        tick = 1'b0;
        got_req = 0;
        for (int c = 0; c < 1400 && got_req == 0; c++) begin
            if (seg_req) got_req = 1;
            else step();
        end
        chk("fetch_reached", got_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_fetch_seg_req", seg_req, 0);
        chk("rst_fetch_busy", busy, 0);
        chk("rst_fetch_wr_en", wr_en, 0);
        step();
        reset = 1'b0;

        clear_segs();
        f_cnt = 3; f_food_v = 1; f_fx = 10; f_fy = 10;
        sx[0] = 1; sy[0] = 1; sx[1] = 39; sy[1] = 0; sx[2] = 0; sy[2] = 0; dly[1] = 2;
        run_frame("after_reset", 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
